// File: rtl/galois_pkg.sv
// Shared constants and types for the BN254 modular-add arbiter slice.
package galois_pkg;

  localparam int N_BITS = 254;

  localparam logic [255:0] P_FULL =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam logic [N_BITS-1:0] P_MOD = P_FULL[N_BITS-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/galois_add.sv
// Combinational BN254 modular adder: sum = (num1 + num2) mod P for operands in [0, P-1].
module galois_add
  import galois_pkg::*;
#(
  parameter int N_BITS = galois_pkg::N_BITS
) (
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic [N_BITS-1:0] sum
);

  logic [N_BITS:0] raw_sum;
  logic [N_BITS:0] red_sum;

  // One carry bit is enough: two in-range operands sum to less than 2P.
  assign raw_sum = {1'b0, num1} + {1'b0, num2};
  assign red_sum = raw_sum - {1'b0, P_MOD};
  assign sum     = (raw_sum >= {1'b0, P_MOD}) ? red_sum[N_BITS-1:0] : raw_sum[N_BITS-1:0];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the search loop so no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any) begin
        idx = (int'(ptr) + k) % N_REQ;
        if (req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = ID_W'(idx);
          gnt_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/galois_add_arbiter.sv
// Round-robin sequencer sharing one galois_add among N_REQ requesters (IDLE -> CALC -> DONE).
// Optional operand range check with res_err output: define GALOIS_ADD_ARB_RANGE_CHECK_EN.
module galois_add_arbiter
  import galois_pkg::*;
#(
  parameter int N_BITS = galois_pkg::N_BITS,
  parameter int N_REQ  = 4,
  parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*N_BITS-1:0] req_a,
  input  logic [N_REQ*N_BITS-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [N_BITS-1:0]       res_data,
  output logic [ID_W-1:0]         res_id,
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
  output logic                    res_err,
`endif
  output logic                    busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        state_q,    state_d;
  logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [N_BITS-1:0] op_a_q,     op_a_d;
  logic [N_BITS-1:0] op_b_q,     op_b_d;
  logic [ID_W-1:0]   op_id_q,    op_id_d;
  logic [N_BITS-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q,   res_id_d;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic [N_REQ-1:0]  ready_raw;
  logic [N_BITS-1:0] sel_a, sel_b;
  logic [N_BITS-1:0] add_sum;
  logic [N_BITS-1:0] calc_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  galois_add #(
    .N_BITS (N_BITS)
  ) u_galois_add (
    .num1 (op_a_q),
    .num2 (op_b_q),
    .sum  (add_sum)
  );

  assign sel_a = req_a[int'(gnt_idx)*N_BITS +: N_BITS];
  assign sel_b = req_b[int'(gnt_idx)*N_BITS +: N_BITS];

`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
  logic op_err;
  logic res_err_q, res_err_d;

  assign op_err    = (op_a_q >= P_MOD) || (op_b_q >= P_MOD);
  assign calc_data = op_err ? '0 : add_sum;
  assign res_err   = res_err_q;
`else
  assign calc_data = add_sum;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_id_d    = op_id_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    ready_raw  = '0;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
    res_err_d  = res_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          ready_raw = gnt;
          op_a_d    = sel_a;
          op_b_d    = sel_b;
          op_id_d   = gnt_idx;
          rr_ptr_d  = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        res_data_d = calc_data;
        res_id_d   = op_id_q;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
        res_err_d  = op_err;
`endif
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: datapath registers are cleared as well, so an aborted operation leaves every output at 0.
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
      res_err_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_id_q    <= op_id_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
      res_err_q  <= res_err_d;
`endif
    end
  end

  // Grants are suppressed combinationally while reset is held.
  assign req_ready = rst ? ready_raw : '0;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_galois_add_arbiter.sv
// Self-checking bench: directed cases plus randomized traffic against a transaction-level model.
module tb_galois_add_arbiter;
  import galois_pkg::*;

  localparam int NB = 254;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*NB-1:0] req_a = '0;
  logic [NR*NB-1:0] req_b = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [NB-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic            busy;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
  logic            res_err;
`endif

  galois_add_arbiter #(
    .N_BITS (NB),
    .N_REQ  (NR),
    .ID_W   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
    .res_err   (res_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference state: at most one operation outstanding, result due two cycles after its grant.
  logic [255:0]  P;
  logic [NB-1:0] op_a [NR];
  logic [NB-1:0] op_b [NR];
  bit            m_pend;
  logic [255:0]  m_data;
  bit            m_err;
  int            m_id;
  int            m_due;
  int            m_ptr;
  int            cyc;

  logic [255:0]  last_data;
  int            last_id;
  bit            last_err;
  int            hand_cyc [$];
  int            hand_id [$];
  logic [255:0]  hand_data [$];

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [255:0] ref_add(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [255:0] s;
    s = {2'b00, a} + {2'b00, b};
    return s % P;
  endfunction

  function automatic logic [NB-1:0] rand_op(input bit allow_oor);
    logic [255:0] r;
    int sel;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    r = r % P;
    sel = $urandom_range(0, 7);
    case (sel)
      0: r = '0;
      1: r = P - 1;
      2: r = 256'd1;
      3: if (allow_oor) r = P + 256'($urandom_range(0, 3));
      default: ;
    endcase
    return r[NB-1:0];
  endfunction

  // One clock cycle: drive, compare against the model, then advance model and clock.
  task automatic step(input logic [NR-1:0] v, input logic rr, output int g);
    logic [NR-1:0] exp_ready;
    bit exp_valid;
    req_valid = v;
    res_ready = rr;
    for (int i = 0; i < NR; i++) begin
      req_a[i*NB +: NB] = op_a[i];
      req_b[i*NB +: NB] = op_b[i];
    end
    #1;
    g = -1;
    exp_ready = '0;
    exp_valid = 1'b0;
    if (!m_pend) begin
      g = pick(v, m_ptr);
      if (g >= 0) exp_ready[g] = 1'b1;
    end else begin
      exp_valid = (cyc >= m_due);
    end
    check("req_ready", 256'(req_ready), 256'(exp_ready));
    check("res_valid", 256'(res_valid), 256'(exp_valid));
    check("busy", 256'(busy), 256'(m_pend));
    if (exp_valid && res_valid) begin
      check("res_data", 256'(res_data), m_data);
      check("res_id", 256'(res_id), 256'(m_id));
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
      check("res_err", 256'(res_err), 256'(m_err));
`endif
    end
    if (g >= 0) begin
      m_pend = 1'b1;
      m_id   = g;
      m_due  = cyc + 2;
      m_ptr  = (g + 1) % NR;
      m_err  = 1'b0;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
      m_err  = ({2'b00, op_a[g]} >= P) || ({2'b00, op_b[g]} >= P);
`endif
      m_data = m_err ? 256'd0 : ref_add(op_a[g], op_b[g]);
    end else if (exp_valid && rr) begin
      m_pend    = 1'b0;
      last_data = 256'(res_data);
      last_id   = int'(res_id);
      last_err  = 1'b0;
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
      last_err  = res_err;
`endif
      hand_cyc.push_back(cyc);
      hand_id.push_back(last_id);
      hand_data.push_back(last_data);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input logic [NR-1:0] v);
    rst       = 1'b0;
    req_valid = v;
    res_ready = 1'b0;
    #1;
    check("rst_ready_comb", 256'(req_ready), 256'd0);
    @(posedge clk);
    #1;
    check("rst_valid", 256'(res_valid), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_data", 256'(res_data), 256'd0);
    check("rst_id", 256'(res_id), 256'd0);
    check("rst_ready", 256'(req_ready), 256'd0);
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
    check("rst_err", 256'(res_err), 256'd0);
`endif
    m_pend = 1'b0;
    m_ptr  = 0;
    cyc++;
    rst = 1'b1;
  endtask

  task automatic one_op(input int idx, input logic [NB-1:0] a, input logic [NB-1:0] b);
    int g;
    op_a[idx] = a;
    op_b[idx] = b;
    step(NR'(1 << idx), 1'b1, g);
    step('0, 1'b1, g);
    step('0, 1'b1, g);
  endtask

  initial begin
    int g;
    logic [NR-1:0] v;
    P = {2'b00, P_MOD};
    for (int i = 0; i < NR; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    m_pend = 1'b0; m_ptr = 0; cyc = 0; m_id = 0; m_due = 0; m_data = '0; m_err = 1'b0;
    last_data = '0; last_id = 0; last_err = 1'b0;
    @(posedge clk);
    #1;
    apply_reset('1);

    // Basic add from requester 2.
    one_op(2, NB'(1), NB'(2));
    check("basic_data", last_data, 256'd3);
    check("basic_id", 256'(last_id), 256'd2);

    // Modular wrap.
    one_op(0, NB'(P - 1), NB'(5));
    check("wrap_p1_5", last_data, 256'd4);
    one_op(0, NB'(P - 1), NB'(1));
    check("wrap_p1_1", last_data, 256'd0);

`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
    one_op(1, NB'(P), NB'(1));
    check("range_err", 256'(last_err), 256'd1);
    check("range_data", last_data, 256'd0);
    one_op(1, NB'(3), NB'(4));
    check("range_ok_err", 256'(last_err), 256'd0);
    check("range_ok_data", last_data, 256'd7);
`endif

    // Backpressure: five stalled DONE cycles with everyone requesting, then release.
    for (int i = 0; i < NR; i++) begin
      op_a[i] = rand_op(1'b0);
      op_b[i] = rand_op(1'b0);
    end
    step('1, 1'b0, g);
    step('1, 1'b0, g);
    for (int k = 0; k < 5; k++) step('1, 1'b0, g);
    step('1, 1'b1, g);
    step('1, 1'b0, g);
    check("bp_regrant", 256'(g >= 0), 256'd1);

    // Reset while the new grant sits in CALC; the next grant must go to requester 0.
    apply_reset('1);
    step('1, 1'b1, g);
    check("rst_next_grant", 256'(g), 256'd0);
    step('0, 1'b1, g);
    step('0, 1'b1, g);

    // Fairness: all requesters valid, A=i, B=10, downstream always ready.
    apply_reset('0);
    for (int i = 0; i < NR; i++) begin
      op_a[i] = NB'(i);
      op_b[i] = NB'(10);
    end
    hand_cyc.delete();
    hand_id.delete();
    hand_data.delete();
    for (int k = 0; k < 16; k++) step('1, 1'b1, g);
    check("fair_count", 256'(hand_id.size() >= 5), 256'd1);
    for (int k = 0; k < 5 && k < hand_id.size(); k++) begin
      check("fair_id", 256'(hand_id[k]), 256'(k % NR));
      check("fair_data", hand_data[k], 256'((k % NR) + 10));
      if (k > 0) check("fair_gap", 256'(hand_cyc[k] - hand_cyc[k-1]), 256'd3);
    end

    // Randomized traffic; a requester's operands change only while it is idle.
    v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v[i]) begin
`ifdef GALOIS_ADD_ARB_RANGE_CHECK_EN
          op_a[i] = rand_op(1'b1);
          op_b[i] = rand_op(1'b1);
`else
          op_a[i] = rand_op(1'b0);
          op_b[i] = rand_op(1'b0);
`endif
          v[i] = ($urandom_range(0, 2) != 0);
        end
      end
      step(v, ($urandom_range(0, 3) != 0), g);
      if (g >= 0) v[g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
